// File: rtl/controlador_memoria.sv
// Load/store controller between the memory stage and a word-addressed data RAM.
// Sub-word access is enabled by defining CONTROLADOR_MEMORIA_SUBPALABRA_EN.
module controlador_memoria #(
    parameter int LARGO = 1024,
    parameter int ANCHO = 32,
    localparam int AW = $clog2(LARGO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [AW+1:0]    req_addr,
    input  logic [ANCHO-1:0] req_wdata,
    output logic             resp_valid,
    output logic [ANCHO-1:0] resp_rdata,
    output logic             resp_error,
    output logic             mem_write_enable,
    output logic [AW-1:0]    mem_addr,
    output logic [ANCHO-1:0] mem_din,
    input  logic [ANCHO-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ACCESO, ESCRITURA, RESPUESTA} estado_t;

    estado_t          estado, estado_sig;
    logic             aceptar;
    logic             error_req;
    logic             we_q;
    logic [ANCHO-1:0] dato_carga;
`ifdef CONTROLADOR_MEMORIA_SUBPALABRA_EN
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic [15:0]      wdata_q;
    logic [7:0]       byte_sel;
    logic [15:0]      media_sel;
    logic [ANCHO-1:0] fusion;
`endif

    assign aceptar = req_valid && req_ready;

    // Legality and alignment are decided from the live request at accept.
    always_comb begin
`ifdef CONTROLADOR_MEMORIA_SUBPALABRA_EN
        case (req_funct3)
            3'b000:         error_req = 1'b0;
            3'b001:         error_req = req_addr[0];
            3'b010:         error_req = |req_addr[1:0];
            3'b100, 3'b101: error_req = req_we | (req_funct3[0] & req_addr[0]);
            default:        error_req = 1'b1;
        endcase
`else
        error_req = (req_funct3 != 3'b010) || (|req_addr[1:0]);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE: begin
                if (aceptar) begin
                    if (error_req)                 estado_sig = RESPUESTA;
                    else if (!req_we)              estado_sig = ACCESO;
                    else if (req_funct3 == 3'b010) estado_sig = ESCRITURA;
                    else                           estado_sig = ACCESO;
                end
            end
            ACCESO:    estado_sig = we_q ? ESCRITURA : RESPUESTA;
            ESCRITURA: estado_sig = RESPUESTA;
            RESPUESTA: estado_sig = IDLE;
            default:   estado_sig = IDLE;
        endcase
    end

    always_comb begin
        req_ready        = (estado == IDLE);
        resp_valid       = (estado == RESPUESTA);
        mem_write_enable = (estado == ESCRITURA) && rst_n;
    end

`ifdef CONTROLADOR_MEMORIA_SUBPALABRA_EN
    always_comb begin
        case (offset_q)
            2'd0:    byte_sel = mem_dout[7:0];
            2'd1:    byte_sel = mem_dout[15:8];
            2'd2:    byte_sel = mem_dout[23:16];
            default: byte_sel = mem_dout[31:24];
        endcase
        media_sel = offset_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (funct3_q)
            3'b000:  dato_carga = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  dato_carga = {{16{media_sel[15]}}, media_sel};
            3'b100:  dato_carga = {24'd0, byte_sel};
            3'b101:  dato_carga = {16'd0, media_sel};
            default: dato_carga = mem_dout;
        endcase
    end

    // Read-modify-write: only the addressed lanes take the new store data.
    always_comb begin
        fusion = mem_dout;
        if (funct3_q[0]) begin
            if (offset_q[1]) fusion[31:16] = wdata_q;
            else             fusion[15:0]  = wdata_q;
        end else begin
            case (offset_q)
                2'd0:    fusion[7:0]   = wdata_q[7:0];
                2'd1:    fusion[15:8]  = wdata_q[7:0];
                2'd2:    fusion[23:16] = wdata_q[7:0];
                default: fusion[31:24] = wdata_q[7:0];
            endcase
        end
    end
`else
    assign dato_carga = mem_dout;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
`ifdef CONTROLADOR_MEMORIA_SUBPALABRA_EN
            funct3_q   <= '0;
            offset_q   <= '0;
            wdata_q    <= '0;
`endif
        end else begin
            case (estado)
                IDLE: begin
                    if (aceptar) begin
                        we_q     <= req_we;
                        mem_addr <= req_addr[AW+1:2];
`ifdef CONTROLADOR_MEMORIA_SUBPALABRA_EN
                        funct3_q <= req_funct3;
                        offset_q <= req_addr[1:0];
                        wdata_q  <= req_wdata[15:0];
`endif
                        if (error_req) begin
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            mem_din <= req_wdata;
                        end
                    end
                end
                ACCESO: begin
                    if (we_q) begin
`ifdef CONTROLADOR_MEMORIA_SUBPALABRA_EN
                        mem_din <= fusion;
`endif
                    end else begin
                        resp_rdata <= dato_carga;
                        resp_error <= 1'b0;
                    end
                end
                ESCRITURA: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_memoria.sv
// Directed self-checking bench for controlador_memoria with a behavioural RAM.
module tb_controlador_memoria;

    localparam int LARGO = 1024;
    localparam int AW    = $clog2(LARGO);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          mem_write_enable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    logic [31:0]   ram [0:LARGO-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    int checks = 0;
    int errors = 0;

    controlador_memoria #(.LARGO(LARGO), .ANCHO(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_addr] <= mem_din;
        else if (pre_we)      ram[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic precarga(input logic [AW-1:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issues one request from IDLE and follows it cycle by cycle to the next IDLE.
    task automatic hacer(input string tag, input logic we, input logic [2:0] f3,
                         input logic [AW+1:0] a, input logic [31:0] wd, input int lat,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_wr);
        int escrituras = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (mem_write_enable) escrituras++;
            chk({tag, " resp_valid"}, {31'd0, resp_valid}, {31'd0, c == lat});
            if (c == lat) begin
                chk({tag, " rdata"}, resp_rdata, exp_rd);
                chk({tag, " error"}, {31'd0, resp_error}, {31'd0, exp_err});
            end else begin
                chk({tag, " busy ready"}, {31'd0, req_ready}, 32'd0);
            end
            @(posedge clk); #1;
        end
        chk({tag, " pulse end"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " ready after"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " writes"}, escrituras, exp_wr);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst mem_din", mem_din, 32'd0);
        chk("rst we", {31'd0, mem_write_enable}, 32'd0);
        rst_n = 1'b1;
        chk("rst ready", {31'd0, req_ready}, 32'd1);

        precarga(10'd4, 32'h876543A1);
`ifdef CONTROLADOR_MEMORIA_SUBPALABRA_EN
        hacer("LB 10",  1'b0, 3'b000, 12'h010, '0, 2, 32'hFFFFFFA1, 1'b0, 0);
        hacer("LBU 13", 1'b0, 3'b100, 12'h013, '0, 2, 32'h00000087, 1'b0, 0);
        hacer("LH 12",  1'b0, 3'b001, 12'h012, '0, 2, 32'hFFFF8765, 1'b0, 0);
        hacer("LHU 12", 1'b0, 3'b101, 12'h012, '0, 2, 32'h00008765, 1'b0, 0);
`else
        hacer("LB 10 off", 1'b0, 3'b000, 12'h010, '0, 1, 32'h0, 1'b1, 0);
`endif
        hacer("LW 10", 1'b0, 3'b010, 12'h010, '0, 2, 32'h876543A1, 1'b0, 0);

        hacer("LW 06",  1'b0, 3'b010, 12'h006, '0, 1, 32'h0, 1'b1, 0);
        hacer("SH 05",  1'b1, 3'b001, 12'h005, 32'h0000BEEF, 1, 32'h0, 1'b1, 0);
        hacer("f3 011", 1'b0, 3'b011, 12'h010, '0, 1, 32'h0, 1'b1, 0);
        hacer("S 100",  1'b1, 3'b100, 12'h010, 32'h12345678, 1, 32'h0, 1'b1, 0);
        chk("word4 untouched", ram[4], 32'h876543A1);

`ifdef CONTROLADOR_MEMORIA_SUBPALABRA_EN
        precarga(10'd4, 32'h11223344);
        hacer("SB 11", 1'b1, 3'b000, 12'h011, 32'hDEADBECC, 3, 32'h0, 1'b0, 1);
        chk("SB word4", ram[4], 32'h1122CC44);
        hacer("SH 12", 1'b1, 3'b001, 12'h012, 32'h0000BEEF, 3, 32'h0, 1'b0, 1);
        chk("SH word4", ram[4], 32'hBEEFCC44);
`endif

        // SW then LW held valid back to back
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 12'h020;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_we = 1'b0; req_wdata = '0;
        chk("b2b ready +1", {31'd0, req_ready}, 32'd0);
        chk("b2b we +1", {31'd0, mem_write_enable}, 32'd1);
        @(posedge clk); #1;
        chk("b2b sw resp", {31'd0, resp_valid}, 32'd1);
        chk("b2b sw rdata", resp_rdata, 32'd0);
        chk("b2b ready +2", {31'd0, req_ready}, 32'd0);
        chk("b2b word8", ram[8], 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("b2b idle ready", {31'd0, req_ready}, 32'd1);
        chk("b2b idle pulse", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b lw busy", {31'd0, req_ready}, 32'd0);
        chk("b2b lw early", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("b2b lw resp", {31'd0, resp_valid}, 32'd1);
        chk("b2b lw rdata", resp_rdata, 32'hCAFEF00D);
        chk("b2b lw error", {31'd0, resp_error}, 32'd0);
        @(posedge clk); #1;
        chk("b2b lw ready", {31'd0, req_ready}, 32'd1);

        // Reset during ESCRITURA drops the write
        precarga(10'd12, 32'h0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 12'h030;
        req_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstw we before", {31'd0, mem_write_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw we gated", {31'd0, mem_write_enable}, 32'd0);
        @(posedge clk); #1;
        chk("rstw word12", ram[12], 32'h0);
        chk("rstw resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstw resp_error", {31'd0, resp_error}, 32'd0);
        chk("rstw resp_rdata", resp_rdata, 32'd0);
        chk("rstw mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rstw mem_din", mem_din, 32'd0);
        rst_n = 1'b1;
        chk("rstw ready", {31'd0, req_ready}, 32'd1);
        hacer("LW 30", 1'b0, 3'b010, 12'h030, '0, 2, 32'h0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
